// File: rtl/shift_add_multiplier.sv
// shift_add_multiplier
//   Sequential unsigned WIDTH x WIDTH shift-and-add multiplier controller.
//   It drives an external combinational WIDTH-bit ripple adder and folds the
//   adder's sum/carry back into an {A,Q} register pair. One add-and-shift is
//   done per cycle, and the 2*WIDTH product is ready WIDTH edges after a start
//   is accepted.
//
//   Optional build macro: MUL_ADDER_CHECK_EN
//     When defined, every RUN cycle compares the adder's result against an
//     internal reference add. Any mismatch sets adder_err, which stays set
//     until reset. When undefined, no comparator is built and adder_err is
//     tied low.
//
// Ports
//   clk           rising-edge clock
//   rst           asynchronous, active-high reset
//   start         request a new multiply; sampled only in IDLE or DONE
//   multiplicand  operand M, captured on the accepting edge
//   multiplier    operand Q, captured on the accepting edge
//   busy          high while in RUN
//   done          one-cycle pulse: product was just updated
//   product       last completed result; holds until the next completion
//   add_a         adder operand a (= A)
//   add_b         adder operand b (= Q[0] ? M : 0)
//   add_sum       adder sum
//   add_cout      adder carry-out
//   adder_err     sticky adder-check flag (always 0 without MUL_ADDER_CHECK_EN)

module shift_add_multiplier #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product,
  output logic [WIDTH-1:0]     add_a,
  output logic [WIDTH-1:0]     add_b,
  input  logic [WIDTH-1:0]     add_sum,
  input  logic                 add_cout,
  output logic                 adder_err
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] m_reg;
  logic [CW-1:0]    count;

  // One add-and-shift-right step: the adder carry lands in A's MSB.
  logic [2*WIDTH-1:0] next_aq;
  assign next_aq = {add_cout, add_sum, q_reg[WIDTH-1:1]};

  assign add_a = a_reg;
  assign add_b = q_reg[0] ? m_reg : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      a_reg   <= '0;
      q_reg   <= '0;
      m_reg   <= '0;
      count   <= '0;
      product <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            m_reg <= multiplicand;
            q_reg <= multiplier;
            a_reg <= '0;
            count <= CW'(WIDTH);
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end

        RUN: begin
          count <= count - CW'(1);
          if (count == CW'(1)) begin
            // Last iteration: publish the result. A is cleared so the
            // adder sees A=0 while idle; Q keeps its final value.
            product <= next_aq;
            q_reg   <= next_aq[WIDTH-1:0];
            a_reg   <= '0;
            done    <= 1'b1;
            busy    <= 1'b0;
            state   <= DONE;
          end else begin
            {a_reg, q_reg} <= next_aq;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

`ifdef MUL_ADDER_CHECK_EN
  logic [WIDTH:0] ref_sum;
  assign ref_sum = {1'b0, add_a} + {1'b0, add_b};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      adder_err <= 1'b0;
    end else if (state == RUN && {add_cout, add_sum} != ref_sum) begin
      adder_err <= 1'b1;
    end
  end
`else
  assign adder_err = 1'b0;
`endif

endmodule

// File: doc/shift_add_multiplier.md
Name: shift_add_multiplier

Overview:
- Sequential unsigned WIDTH x WIDTH multiplier controller that drives the operands of the team's combinational four-bit ripple adder and consumes its sum and carry-out.
- It sits directly upstream and downstream of that adder. It presents add_a/add_b each cycle and registers add_sum/add_cout back into a shift-and-add datapath.
- It produces a 2*WIDTH product after WIDTH iterations.

Parameters:
- WIDTH, 4, operand width; must equal the attached adder width.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request a new multiply; sampled only in IDLE or DONE
- multiplicand  input  WIDTH  operand M, captured on the accepting edge
- multiplier  input  WIDTH  operand Q, captured on the accepting edge
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse: product just updated
- product  output  2*WIDTH  last completed result; holds until the next completion
- add_a  output  WIDTH  to adder a
- add_b  output  WIDTH  to adder b
- add_sum  input  WIDTH  from adder sum
- add_cout  input  1  from adder cout
- adder_err  output  1  sticky adder-check flag (see Optional Feature)

Behaviour:
- Reset (async, active-high; takes effect immediately, mid-operation included):
  - state=IDLE.
  - A, Q, M, count, product, busy, done and adder_err all return to 0.
- Registers:
  - A (WIDTH): partial product high half.
  - Q (WIDTH): multiplier / low half.
  - M (WIDTH): multiplicand.
  - count: ceil(log2(WIDTH+1)) bits.
- Combinational adder drive:
  - add_a = A.
  - add_b = Q[0] ? M : 0.
  - Both are valid in every state. Outside RUN, A=0 and Q holds its last value; the adder output is ignored there.
- IDLE:
  - busy=0, done=0.
  - start=1 at an edge: M<=multiplicand, Q<=multiplier, A<=0, count<=WIDTH, go to RUN.
- RUN:
  - busy=1.
  - Each edge: {A,Q} <= {add_cout, add_sum, Q[WIDTH-1:1]}, then count<=count-1. This is one add-and-shift-right; carry enters A's MSB.
  - When count==1 at the edge: product <= {add_cout, add_sum, Q[WIDTH-1:1]}, done<=1, go to DONE.
  - start is ignored in RUN; operands are not re-captured.
- DONE:
  - Lasts exactly one cycle: done=1, busy=0.
  - Next edge: done<=0.
  - If start=1 on that edge, the new operands are accepted and the state goes to RUN (back-to-back). Otherwise it goes to IDLE.
- Latency:
  - start accepted at edge E0; iterations at E1..EWIDTH.
  - product valid and done high in the cycle after EWIDTH, i.e. WIDTH edges after acceptance.
  - Throughput: one result per WIDTH+1 cycles.
- Arithmetic and boundaries:
  - Unsigned only. Full 2*WIDTH result; no overflow is possible.
  - A zero operand gives 0 after the full WIDTH cycles (no early exit).
  - The all-ones case (2^WIDTH-1)^2 must propagate add_cout into A's MSB correctly.
- product changes only at completion edges and reset.

Optional Feature:
- Macro: MUL_ADDER_CHECK_EN.
- Defined:
  - Each RUN edge compares {add_cout, add_sum} against an internal (WIDTH+1)-bit add_a+add_b.
  - On mismatch, adder_err<=1. It is sticky until rst and does not alter datapath behaviour.
- Undefined:
  - No comparator is built; adder_err is tied to 0.
  - The port exists in both builds.

Test Plan:
- 3 x 5: start=1 one cycle with real adder attached -> busy for 4 cycles, then done pulse 1 cycle, product=8'h0F, busy=0.
- 15 x 15 -> product=8'hE1 after 4 iterations (carry path exercised); 0 x 9 and 9 x 0 -> product=8'h00 after full 4 cycles.
- start re-asserted with new operands (7,7) during RUN of 2 x 6 -> ignored; product=8'h0C. Then start held high through DONE with (7,7) -> back-to-back accept; next product=8'h31.
- rst pulsed asynchronously mid-RUN (between clock edges) -> outputs 0 immediately, state IDLE, no done; next 4 x 4 yields 8'h10.
- Exhaustive 256 operand pairs -> every product equals a*b, each done exactly WIDTH edges after acceptance.
- With MUL_ADDER_CHECK_EN: bench forces add_sum bit0 inverted on one RUN cycle -> adder_err=1 and stays 1 until rst. Without the macro: same stimulus -> adder_err stays 0.
